// File: rtl/elevator_scan_ctrl.sv
// elevator_scan_ctrl: SCAN elevator FSM (clk, reset, floor_buttons, estop -> floor, state, dir_up, door_open, requests); `ELEVATOR_HOME_RETURN_EN adds idle park-at-home
module elevator_scan_ctrl #(
  parameter int NUM_FLOORS   = 16,
  parameter int FLOOR_W      = 4,
  parameter int MOVE_TICKS   = 4,
  parameter int DOOR_TICKS   = 8,
  parameter int HOME_FLOOR   = 0,
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] floor_buttons,
  input  logic                  estop,
  output logic [FLOOR_W-1:0]    floor,
  output logic [2:0]            state,
  output logic                  dir_up,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] requests
);
  typedef enum logic [2:0] {
    IDLE      = 3'b000,
    UP        = 3'b001,
    DOWN      = 3'b010,
    STOPPED   = 3'b011,
    DOOR_OPEN = 3'b100
  } state_t;
  localparam int MW = MOVE_TICKS > 1 ? $clog2(MOVE_TICKS) : 1;
  localparam int DW = DOOR_TICKS > 1 ? $clog2(DOOR_TICKS) : 1;
  localparam logic [NUM_FLOORS-1:0] ALL = '1;
  localparam logic [NUM_FLOORS-1:0] ONE = NUM_FLOORS'(1);
  if (FLOOR_W != $clog2(NUM_FLOORS) || HOME_FLOOR >= NUM_FLOORS || IDLE_TIMEOUT < 1) begin : g_bad_cfg
    $error("elevator_scan_ctrl: inconsistent parameters");
  end
  state_t st;
  logic [MW-1:0] move_cnt;
  logic [DW-1:0] door_cnt;
  logic [NUM_FLOORS-1:0] pending, clr, home_set;
  logic [FLOOR_W-1:0] nf;
  logic up_any, dn_any, ahead, behind, step, at_nf, beyond, door_exp;
  assign pending  = requests | floor_buttons;
  assign up_any   = |(pending & (ALL << floor << 1));
  assign dn_any   = |(pending & ~(ALL << floor));
  assign ahead    = dir_up ? up_any : dn_any;
  assign behind   = dir_up ? dn_any : up_any;
  assign step     = (st == UP || st == DOWN) && move_cnt == MW'(MOVE_TICKS - 1);
  assign nf       = st == UP ? floor + 1'b1 : floor - 1'b1;
  assign at_nf    = pending[nf];
  assign beyond   = st == UP ? |(pending & (ALL << nf << 1)) : |(pending & ~(ALL << nf));
  assign door_exp = door_cnt == DW'(DOOR_TICKS - 1);
  // the floor whose door is (or is about to be) open never keeps a latched request
  assign clr = estop ? '0 :
               (st == DOOR_OPEN || (st == IDLE && pending[floor])) ? ONE << floor :
               (step && at_nf) ? ONE << nf : '0;
  assign state     = st;
  assign door_open = st == DOOR_OPEN;
`ifdef ELEVATOR_HOME_RETURN_EN
  logic [$clog2(IDLE_TIMEOUT+1)-1:0] idle_cnt;
  logic idle_run, idle_hit;
  assign idle_run = !estop && st == IDLE && pending == '0 && floor != FLOOR_W'(HOME_FLOOR);
  assign idle_hit = idle_run && idle_cnt == ($bits(idle_cnt))'(IDLE_TIMEOUT - 1);
  assign home_set = idle_hit ? ONE << HOME_FLOOR : '0;
  always_ff @(posedge clk)
    if (reset || !idle_run || idle_hit) idle_cnt <= '0;
    else idle_cnt <= idle_cnt + 1'b1;
`else
  assign home_set = '0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      st       <= IDLE;
      floor    <= '0;
      dir_up   <= 1'b1;
      requests <= '0;
      move_cnt <= '0;
      door_cnt <= '0;
    end else if (estop) begin
      st       <= STOPPED;
      requests <= pending;
      move_cnt <= '0;
      door_cnt <= '0;
    end else begin
      requests <= (pending & ~clr) | home_set;
      case (st)
        IDLE: begin
          move_cnt <= '0;
          door_cnt <= '0;
          if (pending[floor]) st <= DOOR_OPEN;
          else if (up_any && dn_any) st <= dir_up ? UP : DOWN;
          else if (up_any) begin
            st     <= UP;
            dir_up <= 1'b1;
          end else if (dn_any) begin
            st     <= DOWN;
            dir_up <= 1'b0;
          end
        end
        UP, DOWN: begin
          move_cnt <= step ? '0 : move_cnt + 1'b1;
          door_cnt <= '0;
          if (step) begin
            floor <= nf;
            st    <= at_nf ? DOOR_OPEN : beyond ? st : IDLE;
          end
        end
        DOOR_OPEN: begin
          move_cnt <= '0;
          // a re-press of this floor holds the door rather than latching
          door_cnt <= (floor_buttons[floor] || door_exp) ? '0 : door_cnt + 1'b1;
          if (!floor_buttons[floor] && door_exp) begin
            st     <= ahead ? (dir_up ? UP : DOWN) : behind ? (dir_up ? DOWN : UP) : IDLE;
            dir_up <= ahead ? dir_up : behind ? !dir_up : dir_up;
          end
        end
        default: begin
          st       <= IDLE;
          move_cnt <= '0;
          door_cnt <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// tb_elevator_scan_ctrl: directed scoreboard bench for elevator_scan_ctrl
module tb_elevator_scan_ctrl;
  localparam int NF = 16;
  localparam int FW = 4;
  localparam int MT = 4;
  localparam int DT = 8;
  localparam logic [2:0] S_IDLE = 3'b000, S_UP = 3'b001, S_DOWN = 3'b010, S_STOP = 3'b011, S_DOOR = 3'b100;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic estop = 1'b0;
  logic [NF-1:0] floor_buttons = '0;
  logic [FW-1:0] floor;
  logic [2:0] state;
  logic dir_up, door_open;
  logic [NF-1:0] requests;
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  typedef struct {
    string tag;
    int at;
    int fl;
    logic [2:0] st;
  } ev_t;
  ev_t sb[$];
  elevator_scan_ctrl #(
    .NUM_FLOORS(NF), .FLOOR_W(FW), .MOVE_TICKS(MT), .DOOR_TICKS(DT), .HOME_FLOOR(0), .IDLE_TIMEOUT(64)
  ) dut (
    .clk(clk), .reset(reset), .floor_buttons(floor_buttons), .estop(estop),
    .floor(floor), .state(state), .dir_up(dir_up), .door_open(door_open), .requests(requests)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic press(input int f);
    floor_buttons = NF'(1) << f;
    @(negedge clk);
    floor_buttons = '0;
  endtask
  task automatic push(input string tag, input int at, input int fl, input logic [2:0] st);
    ev_t e;
    e.tag = tag;
    e.at = at;
    e.fl = fl;
    e.st = st;
    sb.push_back(e);
  endtask
  task automatic expect_ev();
    ev_t e;
    int budget;
    e = sb.pop_front();
    budget = e.at - cyc + 4;
    while (state !== e.st && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk({e.tag, "_state"}, state, e.st);
    chk({e.tag, "_cycle"}, cyc, e.at);
    chk({e.tag, "_floor"}, floor, e.fl);
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_floor"}, floor, 0);
    chk({tag, "_state"}, state, S_IDLE);
    chk({tag, "_requests"}, requests, 0);
    chk({tag, "_dir_up"}, dir_up, 1);
    chk({tag, "_door_open"}, door_open, 0);
  endtask
  initial begin
    int k;
    tick(3);
    chk_reset("reset");
    reset = 1'b0;
    // long run to the top floor
    press(15);
    k = cyc;
    chk("up15_state", state, S_UP);
    chk("up15_req", requests[15], 1);
    push("door15", k + 60, 15, S_DOOR);
    push("idle15", k + 68, 15, S_IDLE);
    expect_ev();
    chk("door15_open", door_open, 1);
    expect_ev();
    chk("idle15_req", requests, 0);
    chk("idle15_door", door_open, 0);
    // back down to floor 1
    press(1);
    k = cyc;
    chk("down1_state", state, S_DOWN);
    chk("down1_dir", dir_up, 0);
    push("door1", k + 56, 1, S_DOOR);
    push("idle1", k + 64, 1, S_IDLE);
    expect_ev();
    expect_ev();
    // SCAN: 12 requested, then 5 and 2 picked up on the way
    press(12);
    k = cyc;
    chk("scan_dir", dir_up, 1);
    tick(8);
    chk("scan_at3", floor, 3);
    press(5);
    press(2);
    push("door5", k + 16, 5, S_DOOR);
    push("up5", k + 24, 5, S_UP);
    push("door12", k + 52, 12, S_DOOR);
    push("down12", k + 60, 12, S_DOWN);
    push("door2", k + 100, 2, S_DOOR);
    push("idle2", k + 108, 2, S_IDLE);
    expect_ev();
    expect_ev();
    chk("up5_dir", dir_up, 1);
    expect_ev();
    expect_ev();
    chk("down12_dir", dir_up, 0);
    expect_ev();
    expect_ev();
    chk("scan_req", requests, 0);
    // door hold on re-press of the open floor
    press(2);
    k = cyc;
    chk("hold_open", state, S_DOOR);
    chk("hold_req0", requests[2], 0);
    tick(4);
    press(2);
    chk("hold_req1", requests[2], 0);
    chk("hold_door", door_open, 1);
    push("hold_end", k + 13, 2, S_IDLE);
    expect_ev();
    // emergency stop mid-travel
    press(9);
    k = cyc;
    chk("es_up", state, S_UP);
    chk("es_dir", dir_up, 1);
    tick(10);
    chk("es_at4", floor, 4);
    estop = 1'b1;
    tick();
    chk("es_state", state, S_STOP);
    chk("es_floor", floor, 4);
    chk("es_door", door_open, 0);
    press(9);
    press(13);
    chk("es_req9", requests[9], 1);
    chk("es_req13", requests[13], 1);
    chk("es_hold_floor", floor, 4);
    chk("es_hold_dir", dir_up, 1);
    estop = 1'b0;
    tick();
    k = cyc;
    chk("es_rel_state", state, S_IDLE);
    chk("es_rel_floor", floor, 4);
    push("es_up4", k + 1, 4, S_UP);
    push("es_door9", k + 21, 9, S_DOOR);
    expect_ev();
    expect_ev();
    // reset while the door is open and a request is pending
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset("door_reset");
    // estop on the terminal-count edge wins: no floor step
    press(1);
    tick(3);
    estop = 1'b1;
    tick();
    chk("tc_state", state, S_STOP);
    chk("tc_floor", floor, 0);
    estop = 1'b0;
    tick();
    k = cyc;
    push("tc_up", k + 1, 0, S_UP);
    push("tc_door1", k + 5, 1, S_DOOR);
    expect_ev();
    expect_ev();
    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
